mmio_ctrl: RTL and testbench

- Parametrised memory-mapped I/O controller between the CPU memory interface (mem_cmd/mem_addr/write_data/read_data) and RAM plus peripherals.
- Decodes RAM vs I/O space and holds N_OUT writable output registers (LEDs, HEX data).
- Provides a synchronised switch port with sticky change detection, plus an optional timer.
- Replaces tri-state read drivers with a registered read mux and a read-valid strobe.

---
 rtl/mmio_pkg.sv | 20 ++
 rtl/mmio_if.sv | 24 ++
 rtl/mmio_timer.sv | 79 +++++++
 rtl/mmio_ctrl.sv | 144 ++++++++++++++
 tb/tb_mmio_ctrl.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped I/O controller: command codes,
// I/O register offsets and timer control bit positions.
package mmio_pkg;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam int unsigned OFF_OUT   = 32'h00;
    localparam int unsigned OFF_SW    = 32'h40;
    localparam int unsigned OFF_SWCHG = 32'h41;
    localparam int unsigned OFF_TCNT  = 32'h80;
    localparam int unsigned OFF_TCMP  = 32'h81;
    localparam int unsigned OFF_TCTL  = 32'h82;

    localparam int unsigned CTL_EN = 32'd0;
    localparam int unsigned CTL_AR = 32'd1;
    localparam int unsigned CTL_MF = 32'd2;

endpackage

// File: rtl/mmio_if.sv
// CPU memory bus plus RAM side-band between the system (master) and the
// MMIO controller (slave).
interface mmio_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              rd_valid;
    logic              ram_write;
    logic [DATA_W-1:0] ram_dout;

    modport master (
        output mem_cmd, mem_addr, write_data, ram_dout,
        input  read_data, rd_valid, ram_write
    );

    modport slave (
        input  mem_cmd, mem_addr, write_data, ram_dout,
        output read_data, rd_valid, ram_write
    );
endinterface

// File: rtl/mmio_timer.sv
// Free-running compare timer with optional auto-reload and a sticky match
// flag (write-1-to-clear, a simultaneous new match wins over the clear).
module mmio_timer
    import mmio_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              cnt_sel,
    input  logic              cmp_sel,
    input  logic              ctl_sel,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              irq
);

    logic [DATA_W-1:0] count_r;
    logic [DATA_W-1:0] cmp_r;
    logic              en_r;
    logic              ar_r;
    logic              mf_r;
    logic              match_s;
    logic [DATA_W-1:0] cnt_nxt_s;
    logic              mf_nxt_s;

    // Next count / flag: CPU write beats reload, reload beats increment.
    always_comb begin
        match_s   = en_r & (count_r == cmp_r);
        cnt_nxt_s = count_r;
        if (wr_en & cnt_sel) begin
            cnt_nxt_s = wdata;
        end else if (match_s & ar_r) begin
            cnt_nxt_s = '0;
        end else if (en_r) begin
            cnt_nxt_s = count_r + DATA_W'(1);
        end else begin
            cnt_nxt_s = count_r;
        end
        mf_nxt_s = match_s | (mf_r & ~(wr_en & ctl_sel & wdata[CTL_MF]));
    end

    // Timer state registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r <= '0;
            cmp_r   <= '1;
            en_r    <= 1'b0;
            ar_r    <= 1'b0;
            mf_r    <= 1'b0;
        end else begin
            count_r <= cnt_nxt_s;
            mf_r    <= mf_nxt_s;
            if (wr_en & cmp_sel) cmp_r <= wdata;
            if (wr_en & ctl_sel) begin
                en_r <= wdata[CTL_EN];
                ar_r <= wdata[CTL_AR];
            end
        end
    end

    // Read port, zero when no timer register is addressed.
    always_comb begin
        rd_data = '0;
        if (cnt_sel) begin
            rd_data = count_r;
        end else if (cmp_sel) begin
            rd_data = cmp_r;
        end else if (ctl_sel) begin
            rd_data = {{(DATA_W-3){1'b0}}, mf_r, ar_r, en_r};
        end else begin
            rd_data = '0;
        end
    end

    assign irq = mf_r;

endmodule

// File: rtl/mmio_ctrl.sv
// Memory-mapped I/O controller: RAM/I-O decode, output registers, switch
// port with sticky change detect, registered read mux. Timer under MMIO_TIMER_EN.
module mmio_ctrl
    import mmio_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int N_OUT  = 2,
    parameter int IN_W   = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    mmio_if.slave                   bus,
    input  logic [IN_W-1:0]         sw_in,
    output logic [N_OUT*DATA_W-1:0] out_regs,
    output logic                    irq
);

    localparam int OFF_W = ADDR_W - 1;
    localparam logic [OFF_W-1:0] A_SW    = OFF_W'(OFF_SW);
    localparam logic [OFF_W-1:0] A_SWCHG = OFF_W'(OFF_SWCHG);

    logic              rd_s;
    logic              wr_s;
    logic              io_s;
    logic [OFF_W-1:0]  off_s;
    logic [N_OUT-1:0]  out_hit_s;
    logic [DATA_W-1:0] out_rd_s;
    logic [DATA_W-1:0] tmr_rd_s;
    logic [DATA_W-1:0] io_rd_s;
    logic [DATA_W-1:0] rdata_s;
    logic              clr_s;

    logic [IN_W-1:0]   s1_r, s2_r, s3_r, chg_r;
    logic              rd_valid_r;
    logic              sel_ram_r;
    logic [DATA_W-1:0] io_q_r;
    logic [DATA_W-1:0] last_r;

    assign io_s  = bus.mem_addr[ADDR_W-1];
    assign off_s = bus.mem_addr[OFF_W-1:0];

    // Command decode; the reserved encoding behaves as no command.
    always_comb begin
        rd_s = 1'b0;
        wr_s = 1'b0;
        case (bus.mem_cmd)
            MREAD:   rd_s = 1'b1;
            MWRITE:  wr_s = 1'b1;
            MNONE:   begin rd_s = 1'b0; wr_s = 1'b0; end
            default: begin rd_s = 1'b0; wr_s = 1'b0; end
        endcase
    end

    assign bus.ram_write = wr_s & ~io_s;

    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        logic [DATA_W-1:0] val_r;
        assign out_hit_s[k] = io_s & (off_s == OFF_W'(OFF_OUT + k));
        // Output register k.
        always_ff @(posedge clk) begin
            if (!reset) begin
                val_r <= '0;
            end else if (wr_s & out_hit_s[k]) begin
                val_r <= bus.write_data;
            end
        end
        assign out_regs[k*DATA_W +: DATA_W] = val_r;
    end

`ifdef MMIO_TIMER_EN
    logic cnt_sel_s, cmp_sel_s, ctl_sel_s;
    assign cnt_sel_s = io_s & (off_s == OFF_W'(OFF_TCNT));
    assign cmp_sel_s = io_s & (off_s == OFF_W'(OFF_TCMP));
    assign ctl_sel_s = io_s & (off_s == OFF_W'(OFF_TCTL));

    mmio_timer #(.DATA_W(DATA_W)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_s),
        .cnt_sel (cnt_sel_s),
        .cmp_sel (cmp_sel_s),
        .ctl_sel (ctl_sel_s),
        .wdata   (bus.write_data),
        .rd_data (tmr_rd_s),
        .irq     (irq)
    );
`else
    assign tmr_rd_s = '0;
    assign irq      = 1'b0;
`endif

    // I/O read mux; unmapped offsets fall through to zero.
    always_comb begin
        out_rd_s = '0;
        for (int k = 0; k < N_OUT; k++) begin
            out_rd_s = out_rd_s | (out_hit_s[k] ? out_regs[k*DATA_W +: DATA_W] : '0);
        end
        case (off_s)
            A_SW:    io_rd_s = DATA_W'(s2_r);
            A_SWCHG: io_rd_s = DATA_W'(chg_r);
            default: io_rd_s = out_rd_s | tmr_rd_s;
        endcase
    end

    assign clr_s = rd_s & io_s & (off_s == A_SWCHG);

    // Switch synchroniser, history and sticky change status (set beats clear).
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_r  <= '0;
            s2_r  <= '0;
            s3_r  <= '0;
            chg_r <= '0;
        end else begin
            s1_r  <= sw_in;
            s2_r  <= s1_r;
            s3_r  <= s2_r;
            chg_r <= (chg_r & ~{IN_W{clr_s}}) | (s2_r ^ s3_r);
        end
    end

    // Read pipeline: capture source select and I/O value, then hold result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_valid_r <= 1'b0;
            sel_ram_r  <= 1'b0;
            io_q_r     <= '0;
            last_r     <= '0;
        end else begin
            rd_valid_r <= rd_s;
            if (rd_s) begin
                sel_ram_r <= ~io_s;
                io_q_r    <= io_rd_s;
            end
            if (rd_valid_r) last_r <= rdata_s;
        end
    end

    assign rdata_s       = sel_ram_r ? bus.ram_dout : io_q_r;
    assign bus.read_data = rd_valid_r ? rdata_s : last_r;
    assign bus.rd_valid  = rd_valid_r;

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed, table-driven bench for mmio_ctrl with a behavioural RAM model.
module tb_mmio_ctrl;
    import mmio_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  sw_in;
    logic [31:0] out_regs;
    logic        irq;
    logic        ramw_seen;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] mem [0:255];

    mmio_if #(.ADDR_W(9), .DATA_W(16)) bus ();

    mmio_ctrl #(.ADDR_W(9), .DATA_W(16), .N_OUT(2), .IN_W(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .sw_in    (sw_in),
        .out_regs (out_regs),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_write) mem[bus.mem_addr[7:0]] <= bus.write_data;
        bus.ram_dout <= mem[bus.mem_addr[7:0]];
    end

    typedef struct {
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [15:0] wdata;
        logic        exp_ramw;
        logic        exp_vld;
        logic [15:0] exp_rd;
        logic [31:0] exp_out;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        bus.mem_cmd    = c;
        bus.mem_addr   = a;
        bus.write_data = d;
        #1;
        ramw_seen = bus.ram_write;
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string name, input logic [8:0] a, input logic [15:0] exp);
        step(MREAD, a, 16'h0000);
        chk({name, "_vld"}, {31'd0, bus.rd_valid}, 32'd1);
        chk(name, {16'd0, bus.read_data}, {16'd0, exp});
    endtask

    vec_t vecs [15];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        reset = 1'b0;
        sw_in = 10'h000;
        bus.ram_dout = 16'h0000;
        step(MNONE, 9'h000, 16'h0000);
        step(MNONE, 9'h000, 16'h0000);
        chk("rst_vld", {31'd0, bus.rd_valid}, 32'd0);
        chk("rst_rdata", {16'd0, bus.read_data}, 32'd0);
        chk("rst_out", out_regs, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b1;

        vecs[0]  = '{MWRITE, 9'h100, 16'h00A5, 1'b0, 1'b0, 16'h0000, 32'h0000_00A5};
        vecs[1]  = '{MWRITE, 9'h101, 16'h1234, 1'b0, 1'b0, 16'h0000, 32'h1234_00A5};
        vecs[2]  = '{MWRITE, 9'h010, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 32'h1234_00A5};
        vecs[3]  = '{MREAD,  9'h010, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 32'h1234_00A5};
        vecs[4]  = '{MREAD,  9'h100, 16'h0000, 1'b0, 1'b1, 16'h00A5, 32'h1234_00A5};
        vecs[5]  = '{MREAD,  9'h101, 16'h0000, 1'b0, 1'b1, 16'h1234, 32'h1234_00A5};
        vecs[6]  = '{MNONE,  9'h000, 16'h0000, 1'b0, 1'b0, 16'h1234, 32'h1234_00A5};
        vecs[7]  = '{MREAD,  9'h1F0, 16'h0000, 1'b0, 1'b1, 16'h0000, 32'h1234_00A5};
        vecs[8]  = '{MWRITE, 9'h1F0, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 32'h1234_00A5};
        vecs[9]  = '{MREAD,  9'h102, 16'h0000, 1'b0, 1'b1, 16'h0000, 32'h1234_00A5};
        vecs[10] = '{2'b11,  9'h010, 16'h1111, 1'b0, 1'b0, 16'h0000, 32'h1234_00A5};
        vecs[11] = '{MREAD,  9'h180, 16'h0000, 1'b0, 1'b1, 16'h0000, 32'h1234_00A5};
        vecs[12] = '{MWRITE, 9'h100, 16'h5A5A, 1'b0, 1'b0, 16'h0000, 32'h1234_5A5A};
        vecs[13] = '{MREAD,  9'h100, 16'h0000, 1'b0, 1'b1, 16'h5A5A, 32'h1234_5A5A};
        vecs[14] = '{MREAD,  9'h010, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 32'h1234_5A5A};

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].cmd, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("v%0d_ramw", i), {31'd0, ramw_seen}, {31'd0, vecs[i].exp_ramw});
            chk($sformatf("v%0d_vld", i), {31'd0, bus.rd_valid}, {31'd0, vecs[i].exp_vld});
            chk($sformatf("v%0d_rdata", i), {16'd0, bus.read_data}, {16'd0, vecs[i].exp_rd});
            chk($sformatf("v%0d_out", i), out_regs, vecs[i].exp_out);
        end

        // Switch value and change status.
        sw_in = 10'h2A5;
        step(MNONE, 9'h000, 16'h0000);
        step(MNONE, 9'h000, 16'h0000);
        rd_chk("sw_val", 9'h140, 16'h02A5);
        step(MNONE, 9'h000, 16'h0000);
        rd_chk("sw_chg_init", 9'h141, 16'h02A5);
        sw_in = 10'h2AD;
        step(MNONE, 9'h000, 16'h0000);
        step(MNONE, 9'h000, 16'h0000);
        step(MNONE, 9'h000, 16'h0000);
        rd_chk("sw_chg_b3", 9'h141, 16'h0008);
        rd_chk("sw_chg_clr", 9'h141, 16'h0000);
        // Edge reaches the change register on the same edge as the clear.
        sw_in = 10'h2A5;
        step(MNONE, 9'h000, 16'h0000);
        step(MNONE, 9'h000, 16'h0000);
        rd_chk("sw_setwin_1", 9'h141, 16'h0000);
        rd_chk("sw_setwin_2", 9'h141, 16'h0008);

`ifdef MMIO_TIMER_EN
        step(MWRITE, 9'h181, 16'h0005);
        step(MWRITE, 9'h182, 16'h0003);
        for (int i = 0; i < 5; i++) step(MNONE, 9'h000, 16'h0000);
        chk("tmr_irq_pre", {31'd0, irq}, 32'd0);
        rd_chk("tmr_cnt5", 9'h180, 16'h0005);
        chk("tmr_irq_set", {31'd0, irq}, 32'd1);
        rd_chk("tmr_cnt0", 9'h180, 16'h0000);
        step(MWRITE, 9'h182, 16'h0004);
        chk("tmr_irq_clr", {31'd0, irq}, 32'd0);
        rd_chk("tmr_ctl", 9'h182, 16'h0000);
        step(MWRITE, 9'h180, 16'h0004);
        rd_chk("tmr_cnt_wr", 9'h180, 16'h0004);
        rd_chk("tmr_cmp", 9'h181, 16'h0005);
`else
        step(MWRITE, 9'h181, 16'h0005);
        step(MWRITE, 9'h182, 16'h0003);
        for (int i = 0; i < 6; i++) step(MNONE, 9'h000, 16'h0000);
        chk("notmr_irq", {31'd0, irq}, 32'd0);
        rd_chk("notmr_ctl", 9'h182, 16'h0000);
        rd_chk("notmr_cmp", 9'h181, 16'h0000);
        rd_chk("notmr_cnt", 9'h180, 16'h0000);
`endif

        // Reset while a read result is pending.
        rd_chk("pre_rst_rd", 9'h100, 16'h5A5A);
        reset = 1'b0;
        step(MREAD, 9'h101, 16'h0000);
        chk("rst2_vld", {31'd0, bus.rd_valid}, 32'd0);
        chk("rst2_rdata", {16'd0, bus.read_data}, 32'd0);
        chk("rst2_out", out_regs, 32'd0);
        chk("rst2_irq", {31'd0, irq}, 32'd0);
        reset = 1'b1;
        rd_chk("post_rst_chg", 9'h141, 16'h0000);
        rd_chk("post_rst_out", 9'h100, 16'h0000);
        rd_chk("post_rst_unmapped", 9'h1F0, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
